// File: rtl/bellek_pkg.sv
// -----------------------------------------------------------------------------
// bellek_pkg
// Shared encodings for the memory-port arbiter (bellek_hakemi) and its grant
// picker (hakem_secici).
//   durum_t     : arbiter FSM states (idle / request / finish)
//   HIBE_*      : grant encodings, also the one-hot grant vector layout
//   SAYAC_W     : width of the optional handshake watchdog counter
// -----------------------------------------------------------------------------
package bellek_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'b00,
    ISTEK = 2'b01,
    BITIR = 2'b11
  } durum_t;

  localparam logic [1:0] HIBE_YOK    = 2'b00;
  localparam logic [1:0] HIBE_BUYRUK = 2'b01;
  localparam logic [1:0] HIBE_VERI   = 2'b10;

  localparam int SAYAC_W = 16;

endpackage

// File: rtl/hakem_secici.sv
// -----------------------------------------------------------------------------
// hakem_secici
// Combinational grant picker between the instruction and data requesters.
// Parameters:
//   ROUND_ROBIN : 1 = on contention grant the port not granted last,
//                 0 = instruction port always wins
// Ports:
//   buyruk_valid_i : instruction request pending
//   veri_valid_i   : data request pending
//   son_veri_i     : 1 when the data port received the most recent grant
//   hibe_o         : one-hot grant (HIBE_BUYRUK / HIBE_VERI / HIBE_YOK)
// -----------------------------------------------------------------------------
module hakem_secici
  import bellek_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       buyruk_valid_i,
  input  logic       veri_valid_i,
  input  logic       son_veri_i,
  output logic [1:0] hibe_o
);

  always_comb begin
    hibe_o = HIBE_YOK;
    if (buyruk_valid_i && veri_valid_i) begin
      // Contention: fixed priority favours instructions; round-robin favours
      // whichever port lost last time.
      if ((ROUND_ROBIN == 0) || son_veri_i) begin
        hibe_o = HIBE_BUYRUK;
      end else begin
        hibe_o = HIBE_VERI;
      end
    end else if (buyruk_valid_i) begin
      hibe_o = HIBE_BUYRUK;
    end else if (veri_valid_i) begin
      hibe_o = HIBE_VERI;
    end
  end

endmodule

// File: rtl/bellek_hakemi.sv
// -----------------------------------------------------------------------------
// bellek_hakemi
// Arbitrates one shared memory port between the instruction-cache miss path
// (read only) and the data load/store path (read/write). One request is
// latched at a time; the memory valid/ready handshake is driven from
// registers and the read word is returned to the winner with a one-cycle
// ready pulse.
//
// Optional feature: define BELLEK_HAKEMI_TIMEOUT_EN to add a watchdog on the
// memory handshake. After TIMEOUT_CYCLES cycles in ISTEK without mem_ready_i
// the request is abandoned, data 0 is returned and hata_o is raised together
// with the ready pulse.
//
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   buyruk_valid_i/addr_i    : instruction fetch request
//   buyruk_ready_o/data_o    : instruction completion pulse and fetched word
//   veri_valid_i/addr_i/wdata_i/wstrb_i : data request (wstrb 0 = read)
//   veri_ready_o/data_o      : data completion pulse and load word
//   mem_valid_o/addr_o/wdata_o/wstrb_o  : latched request to memory
//   mem_ready_i/rdata_i      : memory completion and read data
//   hibe_o                   : current grant (01 instr, 10 data, 00 none)
//   hata_o                   : watchdog expiry flag (only with the macro)
//   mesgul_o                 : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module bellek_hakemi
  import bellek_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buyruk_valid_i,
  input  logic [ADDR_W-1:0]     buyruk_addr_i,
  output logic                  buyruk_ready_o,
  output logic [DATA_W-1:0]     buyruk_data_o,
  input  logic                  veri_valid_i,
  input  logic [ADDR_W-1:0]     veri_addr_i,
  input  logic [DATA_W-1:0]     veri_wdata_i,
  input  logic [DATA_W/8-1:0]   veri_wstrb_i,
  output logic                  veri_ready_o,
  output logic [DATA_W-1:0]     veri_data_o,
  output logic                  mem_valid_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wstrb_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic [1:0]            hibe_o,
`ifdef BELLEK_HAKEMI_TIMEOUT_EN
  output logic                  hata_o,
`endif
  output logic                  mesgul_o
);

  durum_t                durum_q;
  logic [1:0]            hibe_q;
  logic                  son_veri_q;
  logic                  mem_valid_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [DATA_W/8-1:0]   mem_wstrb_q;
  logic                  buyruk_ready_q;
  logic                  veri_ready_q;
  logic [DATA_W-1:0]     buyruk_data_q;
  logic [DATA_W-1:0]     veri_data_q;

  logic [1:0]            secim_d;
  logic                  zaman_asimi_d;
  logic                  bitti_d;
  logic [DATA_W-1:0]     yanit_d;

  hakem_secici #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_secici (
    .buyruk_valid_i (buyruk_valid_i),
    .veri_valid_i   (veri_valid_i),
    .son_veri_i     (son_veri_q),
    .hibe_o         (secim_d)
  );

`ifdef BELLEK_HAKEMI_TIMEOUT_EN
  logic [SAYAC_W-1:0] sayac_q;
  logic               hata_q;

  // Counter starts at 0 in the first ISTEK cycle, so expiry after
  // TIMEOUT_CYCLES cycles is the cycle where it holds TIMEOUT_CYCLES-1.
  assign zaman_asimi_d = !mem_ready_i &&
                         (sayac_q == SAYAC_W'(TIMEOUT_CYCLES - 1));
  assign hata_o        = hata_q;
`else
  logic unused_zaman_asimi;
  assign unused_zaman_asimi = ^TIMEOUT_CYCLES;
  assign zaman_asimi_d      = 1'b0;
`endif

  // An abandoned (timed-out) request returns zero instead of bus garbage.
  assign bitti_d = mem_ready_i | zaman_asimi_d;
  assign yanit_d = mem_ready_i ? mem_rdata_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q        <= BOSTA;
      hibe_q         <= HIBE_YOK;
      son_veri_q     <= 1'b1;  // "last = data" so instructions win first
      mem_valid_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      buyruk_ready_q <= 1'b0;
      veri_ready_q   <= 1'b0;
      buyruk_data_q  <= '0;
      veri_data_q    <= '0;
`ifdef BELLEK_HAKEMI_TIMEOUT_EN
      sayac_q        <= '0;
      hata_q         <= 1'b0;
`endif
    end else begin
      case (durum_q)
        BOSTA: begin
          if (secim_d != HIBE_YOK) begin
            hibe_q      <= secim_d;
            mem_valid_q <= 1'b1;
            if (secim_d == HIBE_VERI) begin
              mem_addr_q  <= veri_addr_i;
              mem_wdata_q <= veri_wdata_i;
              mem_wstrb_q <= veri_wstrb_i;
            end else begin
              mem_addr_q  <= buyruk_addr_i;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
            end
`ifdef BELLEK_HAKEMI_TIMEOUT_EN
            sayac_q     <= '0;
`endif
            durum_q     <= ISTEK;
          end
        end
        ISTEK: begin
          if (bitti_d) begin
            if (hibe_q == HIBE_VERI) begin
              veri_data_q  <= yanit_d;
              veri_ready_q <= 1'b1;
            end else begin
              buyruk_data_q  <= yanit_d;
              buyruk_ready_q <= 1'b1;
            end
            mem_valid_q <= 1'b0;
            son_veri_q  <= (hibe_q == HIBE_VERI);
`ifdef BELLEK_HAKEMI_TIMEOUT_EN
            hata_q      <= zaman_asimi_d;
`endif
            durum_q     <= BITIR;
          end
`ifdef BELLEK_HAKEMI_TIMEOUT_EN
          else begin
            sayac_q <= sayac_q + 1'b1;
          end
`endif
        end
        BITIR: begin
          buyruk_ready_q <= 1'b0;
          veri_ready_q   <= 1'b0;
          hibe_q         <= HIBE_YOK;
`ifdef BELLEK_HAKEMI_TIMEOUT_EN
          hata_q         <= 1'b0;
`endif
          durum_q        <= BOSTA;
        end
        default: durum_q <= BOSTA;
      endcase
    end
  end

  assign buyruk_ready_o = buyruk_ready_q;
  assign buyruk_data_o  = buyruk_data_q;
  assign veri_ready_o   = veri_ready_q;
  assign veri_data_o    = veri_data_q;
  assign mem_valid_o    = mem_valid_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_wstrb_o    = mem_wstrb_q;
  assign hibe_o         = hibe_q;
  assign mesgul_o       = (durum_q != BOSTA);

endmodule

// File: doc/bellek_hakemi.md
Name: bellek_hakemi

Overview:
- Arbitrates the single shared memory port between the instruction cache miss path (read-only) and the data load/store path (read/write).
- Sits between both requesters and the memory controller.
- Latches one request at a time, drives the memory valid/ready handshake, and returns the read data to the winning requester with a one-cycle ready pulse.
- Fixed-priority or round-robin policy, selected by parameter.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; strobe width is DATA_W/8
ROUND_ROBIN, 1, 1 = alternate on contention, 0 = instruction port always wins
TIMEOUT_CYCLES, 255, watchdog limit on the memory handshake (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
buyruk_valid_i  in  1  instruction fetch request
buyruk_addr_i  in  ADDR_W  instruction fetch address
buyruk_ready_o  out  1  one-cycle completion pulse to the instruction cache
buyruk_data_o  out  DATA_W  fetched word, valid while buyruk_ready_o=1
veri_valid_i  in  1  data request
veri_addr_i  in  ADDR_W  data address
veri_wdata_i  in  DATA_W  store data
veri_wstrb_i  in  DATA_W/8  byte strobes; 0 = read, nonzero = write
veri_ready_o  out  1  one-cycle completion pulse to the data path
veri_data_o  out  DATA_W  load data, valid while veri_ready_o=1
mem_valid_o  out  1  request to the memory controller
mem_addr_o  out  ADDR_W  latched address
mem_wdata_o  out  DATA_W  latched store data
mem_wstrb_o  out  DATA_W/8  latched strobes (0 for instruction grants)
mem_ready_i  in  1  memory completion
mem_rdata_i  in  DATA_W  memory read data, sampled when mem_ready_i=1
hibe_o  out  2  current grant: 01 = instruction, 10 = data, 00 = none
mesgul_o  out  1  high in every state except BOSTA

Behaviour:
- Reset values (asynchronous on rst=1): state BOSTA; all *_valid_o, *_ready_o and hibe_o at 0; all data, address and strobe outputs at 0; round-robin pointer "last = data", so the instruction port wins first.
- A reset mid-transaction drops mem_valid_o immediately and produces no ready pulse. The memory controller tolerates an abandoned request.

State BOSTA:
- If no valid is asserted, stay in BOSTA.
- If exactly one valid is asserted, grant it.
- If both are asserted: with ROUND_ROBIN=0 grant the instruction port; with ROUND_ROBIN=1 grant the port not granted last.
- On a grant:
  - latch address, wdata and wstrb;
  - force wstrb to 0 for an instruction grant;
  - set hibe_o;
  - go to ISTEK.
- mem_valid_o is 1 from the next cycle.

State ISTEK:
- mem_valid_o=1; mem_addr_o, mem_wdata_o and mem_wstrb_o are held stable.
- Requester inputs are ignored while in ISTEK.
- On mem_ready_i=1:
  - capture mem_rdata_i into the granted requester's data output register;
  - mem_valid_o goes to 0 at the next edge;
  - update the round-robin pointer;
  - go to BITIR.
- If mem_ready_i is already 1 in the first ISTEK cycle, the transaction completes in that cycle (single-cycle memory).

State BITIR:
- The granted *_ready_o is 1 for exactly this one cycle; the data output holds the captured word.
- hibe_o is cleared at the exit edge; go to BOSTA.
- Requester contract: each requester holds valid and its payload stable until it sees ready, then deasserts or changes its request at that edge. Because BITIR is one cycle, a completed request is never re-granted.
- The non-granted requester waits, with ready held low, and is evaluated again in BOSTA.
- Data outputs keep their last value outside BITIR.

Latency and throughput:
- Request seen in BOSTA at cycle 0 → mem_valid_o=1 at cycle 1.
- mem_ready_i at cycle k → ready pulse at cycle k+1.
- Minimum 3 cycles per transaction; 1 idle cycle between back-to-back grants.
- Under sustained contention with ROUND_ROBIN=1, grants strictly alternate.

Optional Feature:
- Macro: BELLEK_HAKEMI_TIMEOUT_EN.
- With the macro defined:
  - an 8..16-bit counter clears on ISTEK entry and increments each cycle in ISTEK;
  - if it reaches TIMEOUT_CYCLES without mem_ready_i, the block drops mem_valid_o, enters BITIR, returns data 0, and asserts an extra output hata_o (1 bit) together with the ready pulse;
  - hata_o resets to 0.
- Without the macro: no counter and no hata_o port; ISTEK waits indefinitely.

Decomposition:
- Shared package bellek_pkg holds:
  - state encodings BOSTA=2'b00, ISTEK=2'b01, BITIR=2'b11;
  - grant encodings HIBE_YOK=2'b00, HIBE_BUYRUK=2'b01, HIBE_VERI=2'b10.
- One sub-module is natural: hakem_secici, the combinational priority/round-robin pick taking both valids, the pointer and ROUND_ROBIN, and returning a one-hot grant. The FSM and latches stay in the top module.

Test Plan:
1. Instruction read alone: buyruk_valid_i=1, addr 0x0000_0400; mem_ready_i asserted 2 cycles after mem_valid_o with rdata 0x0000_0013 → mem_wstrb_o=0, buyruk_ready_o one-cycle pulse with buyruk_data_o=0x0000_0013, veri_ready_o stays 0.
2. Data write alone: addr 0x1000_0008, wdata 0xDEAD_BEEF, wstrb 4'b1111 → mem_* carry exactly those values; veri_ready_o pulses once; hibe_o=10 during ISTEK.
3. Contention with ROUND_ROBIN=1, both valids held for 4 transactions → grant order instruction, data, instruction, data; with ROUND_ROBIN=0 → all 4 grants go to the instruction port while it stays valid.
4. Single-cycle memory, mem_ready_i tied to 1 → transaction takes 3 cycles; back-to-back requests complete every 3 cycles.
5. Reset asserted asynchronously mid-ISTEK → mem_valid_o and hibe_o are 0 before the next clock edge; no ready pulse; after release, the pending instruction request is granted first.
6. With BELLEK_HAKEMI_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready_i held at 0 → after 8 ISTEK cycles the ready pulse fires with hata_o=1 and data 0; the next transaction has hata_o=0.
